// File: rtl/hazard_detect.sv
// ID-stage hazard/stall controller for the 5-stage LEGv8 pipeline.
// Latency: stall/flush controls are combinational (Mealy) in the cycle the hazard is seen; counters update on the next edge.
// Backpressure: a hazard holds the PC and IF/ID and bubbles ID/EX; a load feeding CB(N)Z holds for two cycles.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   IF_ID_*             source fields and qualifiers of the instruction in ID
//   ID_EX_*             destination / write / load flags of the EX-stage instruction
//   EX_MEM_*            destination / load flag of the MEM-stage instruction
//   BranchTaken         branch decision computed in ID
//   PCWrite/IF_ID_Write 0 holds PC / IF/ID register
//   ID_EX_Bubble        1 zeroes ID/EX control (NOP injection)
//   IF_ID_Flush         1 clears IF/ID on the next edge (taken branch)
//   stall_cnt/flush_cnt saturating counts of bubble cycles and flush cycles

module hazard_detect #(
  parameter int         CNT_W = 16,
  parameter logic [4:0] ZR    = 5'd31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IF_ID_Rn,
  input  logic [4:0]       IF_ID_Rm,
  input  logic [4:0]       IF_ID_Rt,
  input  logic             IF_ID_UsesRn,
  input  logic             IF_ID_UsesRm,
  input  logic             IF_ID_IsCB,
  input  logic [4:0]       ID_EX_Rd,
  input  logic             ID_EX_RegWrite,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       EX_MEM_Rd,
  input  logic             EX_MEM_MemRead,
  input  logic             BranchTaken,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             ID_EX_Bubble,
  output logic             IF_ID_Flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN, STALL} state_t;

  state_t     state;
  logic [1:0] rem;

  // Producer matches. XZR as a destination is never a real producer. The
  // Uses*/IsCB qualifiers come first so that unused (possibly X) source
  // fields cannot create a hazard.
  logic rn_ex_match;
  logic rm_ex_match;
  logic rt_ex_match;
  logic rt_mem_match;

  always_comb begin
    rn_ex_match  = IF_ID_UsesRn && (ID_EX_Rd != ZR) && (IF_ID_Rn == ID_EX_Rd);
    rm_ex_match  = IF_ID_UsesRm && (ID_EX_Rd != ZR) && (IF_ID_Rm == ID_EX_Rd);
    rt_ex_match  = IF_ID_IsCB   && (ID_EX_Rd != ZR) && (IF_ID_Rt == ID_EX_Rd);
    rt_mem_match = IF_ID_IsCB   && (EX_MEM_Rd != ZR) && (IF_ID_Rt == EX_MEM_Rd);
  end

  // Stall cycles still required before the ID instruction may proceed.
  // Load-use needs one cycle (EX->MEM forwarding then covers it). An early
  // branch compares in ID, so an ALU result in EX or a load in MEM costs one
  // cycle, and a load still in EX costs two.
  logic       need_lu;
  logic [1:0] need_cb;
  logic [1:0] need;

  always_comb begin
    need_lu = ID_EX_MemRead && (rn_ex_match || rm_ex_match);

    need_cb = 2'd0;
    if (ID_EX_MemRead && rt_ex_match)
      need_cb = 2'd2;
    else if (ID_EX_RegWrite && rt_ex_match)
      need_cb = 2'd1;
    else if (EX_MEM_MemRead && rt_mem_match)
      need_cb = 2'd1;

    // need_cb is at least 1 whenever it is non-zero, so it dominates need_lu.
    need = (need_cb != 2'd0) ? need_cb : {1'b0, need_lu};
  end

  logic stalling;
  assign stalling = (state == STALL) || (need != 2'd0);

  // Control outputs. Reset forces a clean "run, no flush" pattern so nothing
  // downstream is held or cleared while the controller itself is resetting.
  // A branch decision seen during a stall is ignored: its operand is stale.
  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Bubble = 1'b0;
    IF_ID_Flush  = 1'b0;
    if (!reset) begin
      if (stalling) begin
        PCWrite      = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Bubble = 1'b1;
      end else begin
        IF_ID_Flush  = BranchTaken;
      end
    end
  end

  // State: a two-cycle hazard spends its first cycle in RUN (Mealy stall)
  // and its remaining cycles in STALL, counted down by rem. A one-cycle
  // hazard stays in RUN and is simply re-evaluated on the next cycle, where
  // the advanced pipeline no longer shows the dependency.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      rem   <= 2'd0;
    end else begin
      case (state)
        RUN: begin
          if (need == 2'd2) begin
            rem   <= 2'd1;
            state <= STALL;
          end
        end
        STALL: begin
          if (rem <= 2'd1) begin
            rem   <= 2'd0;
            state <= RUN;
          end else begin
            rem <= rem - 2'd1;
          end
        end
        default: begin
          rem   <= 2'd0;
          state <= RUN;
        end
      endcase
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (ID_EX_Bubble && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (IF_ID_Flush && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_detect.sv
// Directed bench for hazard_detect: expected controls/counters queued per step and checked mid-cycle.
// Latency: each step drives inputs after a rising edge and compares at the following falling edge.
// Backpressure: none; a second instance with CNT_W = 2 shares the stimulus to exercise saturation.

module tb_hazard_detect;

  logic       clk;
  logic       reset;
  logic [4:0] IF_ID_Rn, IF_ID_Rm, IF_ID_Rt;
  logic       IF_ID_UsesRn, IF_ID_UsesRm, IF_ID_IsCB;
  logic [4:0] ID_EX_Rd;
  logic       ID_EX_RegWrite, ID_EX_MemRead;
  logic [4:0] EX_MEM_Rd;
  logic       EX_MEM_MemRead;
  logic       BranchTaken;

  logic        PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush;
  logic [15:0] stall_cnt, flush_cnt;
  logic        s_PCWrite, s_IF_ID_Write, s_ID_EX_Bubble, s_IF_ID_Flush;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  hazard_detect #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .IF_ID_Rn(IF_ID_Rn), .IF_ID_Rm(IF_ID_Rm), .IF_ID_Rt(IF_ID_Rt),
    .IF_ID_UsesRn(IF_ID_UsesRn), .IF_ID_UsesRm(IF_ID_UsesRm), .IF_ID_IsCB(IF_ID_IsCB),
    .ID_EX_Rd(ID_EX_Rd), .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
    .EX_MEM_Rd(EX_MEM_Rd), .EX_MEM_MemRead(EX_MEM_MemRead), .BranchTaken(BranchTaken),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .ID_EX_Bubble(ID_EX_Bubble),
    .IF_ID_Flush(IF_ID_Flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_detect #(.CNT_W(2)) dut_small (
    .clk(clk), .reset(reset),
    .IF_ID_Rn(IF_ID_Rn), .IF_ID_Rm(IF_ID_Rm), .IF_ID_Rt(IF_ID_Rt),
    .IF_ID_UsesRn(IF_ID_UsesRn), .IF_ID_UsesRm(IF_ID_UsesRm), .IF_ID_IsCB(IF_ID_IsCB),
    .ID_EX_Rd(ID_EX_Rd), .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
    .EX_MEM_Rd(EX_MEM_Rd), .EX_MEM_MemRead(EX_MEM_MemRead), .BranchTaken(BranchTaken),
    .PCWrite(s_PCWrite), .IF_ID_Write(s_IF_ID_Write), .ID_EX_Bubble(s_ID_EX_Bubble),
    .IF_ID_Flush(s_IF_ID_Flush), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pcw;
    logic        bub;
    logic        fl;
    logic [15:0] s;
    logic [15:0] f;
    logic [1:0]  ss;
    logic [1:0]  sf;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  // Counter model: counts the expected bubble/flush cycles, saturating.
  logic [15:0] m_s, m_f;
  logic [1:0]  m_ss, m_sf;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input string tag, input logic rst,
                      input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rt,
                      input logic urn, input logic urm, input logic iscb,
                      input logic [4:0] exrd, input logic exrw, input logic exmr,
                      input logic [4:0] memrd, input logic memmr, input logic bt,
                      input logic e_stall, input logic e_flush);
    exp_t e;
    exp_t got;
    reset = rst;
    IF_ID_Rn = rn; IF_ID_Rm = rm; IF_ID_Rt = rt;
    IF_ID_UsesRn = urn; IF_ID_UsesRm = urm; IF_ID_IsCB = iscb;
    ID_EX_Rd = exrd; ID_EX_RegWrite = exrw; ID_EX_MemRead = exmr;
    EX_MEM_Rd = memrd; EX_MEM_MemRead = memmr; BranchTaken = bt;

    e.pcw = ~e_stall; e.bub = e_stall; e.fl = e_flush;
    e.s = m_s; e.f = m_f; e.ss = m_ss; e.sf = m_sf;
    sb.push_back(e);

    if (rst) begin
      m_s = '0; m_f = '0; m_ss = '0; m_sf = '0;
    end else begin
      if (e_stall) begin
        if (m_s != 16'hFFFF) m_s = m_s + 16'd1;
        if (m_ss != 2'd3)    m_ss = m_ss + 2'd1;
      end
      if (e_flush) begin
        if (m_f != 16'hFFFF) m_f = m_f + 16'd1;
        if (m_sf != 2'd3)    m_sf = m_sf + 2'd1;
      end
    end

    @(negedge clk);
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      got = sb.pop_front();
      chk({tag, ".PCWrite"},      {15'd0, PCWrite},       {15'd0, got.pcw});
      chk({tag, ".IF_ID_Write"},  {15'd0, IF_ID_Write},   {15'd0, got.pcw});
      chk({tag, ".ID_EX_Bubble"}, {15'd0, ID_EX_Bubble},  {15'd0, got.bub});
      chk({tag, ".IF_ID_Flush"},  {15'd0, IF_ID_Flush},   {15'd0, got.fl});
      chk({tag, ".stall_cnt"},    stall_cnt,              got.s);
      chk({tag, ".flush_cnt"},    flush_cnt,              got.f);
      chk({tag, ".s_stall_cnt"},  {14'd0, s_stall_cnt},   {14'd0, got.ss});
      chk({tag, ".s_flush_cnt"},  {14'd0, s_flush_cnt},   {14'd0, got.sf});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    IF_ID_Rn = '0; IF_ID_Rm = '0; IF_ID_Rt = '0;
    IF_ID_UsesRn = 1'b0; IF_ID_UsesRm = 1'b0; IF_ID_IsCB = 1'b0;
    ID_EX_Rd = '0; ID_EX_RegWrite = 1'b0; ID_EX_MemRead = 1'b0;
    EX_MEM_Rd = '0; EX_MEM_MemRead = 1'b0; BranchTaken = 1'b0;
    m_s = '0; m_f = '0; m_ss = '0; m_sf = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset held with a hazard and a taken branch present: run pattern, no flush.
    //    tag        rst rn  rm  rt  urn urm cb  exrd rw mr memrd mmr bt  stl fl
    step("rst_hold", 1, 5'd2, 5'd0, 5'd0, 1, 0, 0, 5'd2, 1, 1, 5'd0, 0, 1, 0, 0);
    step("idle0",    0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);

    // LDUR X2 in EX, ADD uses X2: one bubble, then the load has moved to MEM.
    step("lu_1",     0, 5'd2, 5'd0, 5'd0, 1, 0, 0, 5'd2, 1, 1, 5'd0, 0, 0, 1, 0);
    step("lu_2",     0, 5'd2, 5'd0, 5'd0, 1, 0, 0, 5'd0, 0, 0, 5'd2, 1, 0, 0, 0);
    // Load-use through Rm.
    step("lu_rm",    0, 5'd0, 5'd4, 5'd0, 0, 1, 0, 5'd4, 1, 1, 5'd0, 0, 0, 1, 0);
    step("lu_rm2",   0, 5'd0, 5'd4, 5'd0, 0, 1, 0, 5'd0, 0, 0, 5'd4, 1, 0, 0, 0);

    // LDUR X31 never creates a hazard.
    step("xzr",      0, 5'd0, 5'd31, 5'd31, 0, 1, 1, 5'd31, 1, 1, 5'd31, 1, 0, 0, 0);
    // Unused source fields carry X: qualifiers must gate them.
    step("x_fields", 0, 5'bx, 5'bx, 5'bx, 0, 0, 0, 5'd3, 1, 1, 5'd3, 1, 0, 0, 0);
    // Plain taken branch with no hazard flushes.
    step("br_run",   0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 1);

    // LDUR X5 in EX, CBZ X5 in ID, BranchTaken held: 2 stalls then flush.
    step("cbld_1",   0, 5'd0, 5'd0, 5'd5, 0, 0, 1, 5'd5, 1, 1, 5'd0, 0, 1, 1, 0);
    step("cbld_2",   0, 5'd0, 5'd0, 5'd5, 0, 0, 1, 5'd0, 0, 0, 5'd5, 1, 1, 1, 0);
    step("cbld_3",   0, 5'd0, 5'd0, 5'd5, 0, 0, 1, 5'd0, 0, 0, 5'd0, 0, 1, 0, 1);
    step("idle1",    0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);

    // ADD X7 in EX, CBNZ X7 in ID: one stall, then the branch is honoured.
    step("cbalu_1",  0, 5'd0, 5'd0, 5'd7, 0, 0, 1, 5'd7, 1, 0, 5'd0, 0, 1, 1, 0);
    step("cbalu_2",  0, 5'd0, 5'd0, 5'd7, 0, 0, 1, 5'd0, 0, 0, 5'd7, 0, 1, 0, 1);
    // Load of X7 in MEM only: one stall.
    step("cbmem_1",  0, 5'd0, 5'd0, 5'd7, 0, 0, 1, 5'd0, 0, 0, 5'd7, 1, 0, 1, 0);
    step("cbmem_2",  0, 5'd0, 5'd0, 5'd7, 0, 0, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);

    // Reset in the second cycle of a 2-cycle CB stall: no residual stall afterwards.
    step("rstmid_1", 0, 5'd0, 5'd0, 5'd5, 0, 0, 1, 5'd5, 1, 1, 5'd0, 0, 1, 1, 0);
    step("rstmid_2", 1, 5'd0, 5'd0, 5'd5, 0, 0, 1, 5'd0, 0, 0, 5'd5, 1, 1, 0, 0);
    step("rstmid_3", 0, 5'd0, 5'd0, 5'd5, 0, 0, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);

    // Back-to-back load-use stalls: the 2-bit counter reaches 3 and holds.
    for (int i = 0; i < 4; i++)
      step("sat_lu", 0, 5'd2, 5'd0, 5'd0, 1, 0, 0, 5'd2, 1, 1, 5'd0, 0, 0, 1, 0);
    step("sat_hold", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      step("sat_br", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 1);
    step("sat_end",  0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
